// File: rtl/fallthrough_fifo.sv
// fallthrough_fifo: single-clock first-word-fall-through FIFO with occupancy-decoded flags
module fallthrough_fifo #(
    parameter int WIDTH = 72,
    parameter int MAX_DEPTH_BITS = 3,
    parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);
    localparam int DEPTH = 2**MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_C = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] PROG_C = (MAX_DEPTH_BITS+1)'(PROG_FULL_THRESHOLD);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [MAX_DEPTH_BITS:0] count;
    logic wr_ok, rd_ok;
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok) count <= count + 1'b1;
            else if (rd_ok && !wr_ok) count <= count - 1'b1;
        end
    end
    // flags decode only registered occupancy, so there is no path from wr_en/rd_en
    assign dout = mem[rd_ptr];
    assign empty = count == '0;
    assign full = count == DEPTH_C;
    assign nearly_full = count >= DEPTH_C - 1'b1;
    assign prog_full = count >= PROG_C;
endmodule

// File: tb/tb_fallthrough_fifo.sv
// tb_fallthrough_fifo: directed stimulus with a scoreboard queue checked by a pop monitor
module tb_fallthrough_fifo;
    logic clk = 0;
    logic reset = 1;
    logic [7:0] din = '0;
    logic wr_en = 0;
    logic rd_en = 0;
    logic [7:0] dout;
    logic full, nearly_full, prog_full, empty;
    logic [7:0] q[$];
    int n_tests = 0;
    int n_fail = 0;
    int n_pops = 0;

    fallthrough_fifo #(.WIDTH(8), .MAX_DEPTH_BITS(3)) dut (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .full(full), .nearly_full(nearly_full), .prog_full(prog_full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // a pop is accepted at the coming edge: the head on dout must match the scoreboard front
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            n_pops++;
            if (q.size() == 0) chk("pop_unexpected", {24'd0, dout}, 32'hFFFF_FFFF);
            else chk("pop_data", {24'd0, dout}, {24'd0, q.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        reset = 0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_nearly_full", nearly_full, 0);
        chk("rst_prog_full", prog_full, 0);
        chk("rst_dout", dout, 0);

        din = 8'hA5; wr_en = 1; q.push_back(8'hA5);
        step();
        wr_en = 0;
        chk("ft_empty", empty, 0);
        chk("ft_dout", dout, 8'hA5);
        step();
        chk("ft_dout_hold", dout, 8'hA5);
        rd_en = 1;
        step();
        rd_en = 0;
        chk("ft_empty_after_pop", empty, 1);

        for (int i = 1; i <= 9; i++) begin
            din = 8'(i); wr_en = 1;
            if (i <= 8) q.push_back(8'(i));
            step();
            if (i == 7) begin
                chk("fill7_nearly_full", nearly_full, 1);
                chk("fill7_prog_full", prog_full, 1);
                chk("fill7_full", full, 0);
            end
            if (i == 6) chk("fill6_nearly_full", nearly_full, 0);
            if (i >= 8) chk("fill_full", full, 1);
        end
        wr_en = 0;
        chk("fill_head", dout, 8'h01);
        rd_en = 1;
        repeat (8) step();
        rd_en = 0;
        chk("drain_empty", empty, 1);
        chk("drain_sb_left", q.size(), 0);

        rd_en = 1;
        repeat (3) step();
        rd_en = 0;
        chk("uf_empty", empty, 1);
        din = 8'h33; wr_en = 1; q.push_back(8'h33);
        step();
        wr_en = 0;
        chk("uf_dout", dout, 8'h33);
        chk("uf_not_empty", empty, 0);
        rd_en = 1;
        step();
        rd_en = 0;
        chk("uf_single_entry", empty, 1);

        for (int i = 0; i < 20; i++) begin
            din = 8'(8'h10 + i); wr_en = 1; rd_en = 1; q.push_back(8'(8'h10 + i));
            step();
            chk("wrap_head", dout, 8'(8'h10 + i));
            chk("wrap_not_empty", empty, 0);
        end
        wr_en = 0;
        step();
        rd_en = 0;
        chk("wrap_empty", empty, 1);
        chk("wrap_sb_left", q.size(), 0);

        for (int i = 0; i < 5; i++) begin
            din = 8'(8'h50 + i); wr_en = 1; q.push_back(8'(8'h50 + i));
            step();
        end
        chk("mid_count5_head", dout, 8'h50);
        din = 8'h99; reset = 1;
        q.delete();
        step();
        reset = 0; wr_en = 0;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_dout", dout, 0);
        din = 8'h77; wr_en = 1; q.push_back(8'h77);
        step();
        wr_en = 0;
        chk("mid_dout77", dout, 8'h77);
        rd_en = 1;
        step();
        rd_en = 0;
        chk("mid_final_empty", empty, 1);
        chk("total_pops", n_pops, 31);
        chk("sb_final", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fallthrough_fifo.md
# fallthrough_fifo

Single-clock, first-word-fall-through (FWFT) FIFO used as the ingress packet buffer in the stream parser. It stores AXI-Stream beats packed as one `{tlast, tuser, tkeep, tdata}` word. The head entry is presented on `dout` whenever the FIFO is not empty, and `rd_en` pops it. The `nearly_full` output drives upstream `tready` backpressure.

## Interface
Parameters:
- `WIDTH`, default 72: word width in bits.
- `MAX_DEPTH_BITS`, default 3: depth is 2**MAX_DEPTH_BITS entries.
- `PROG_FULL_THRESHOLD`, default 2**MAX_DEPTH_BITS - 1: occupancy at which `prog_full` asserts.

Ports:
- `clk`  in  1: sole clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `din`  in  WIDTH: write data.
- `wr_en`  in  1: write request.
- `rd_en`  in  1: pop request for the head entry.
- `dout`  out  WIDTH: head entry, valid while `empty`=0.
- `full`  out  1: occupancy equals 2**MAX_DEPTH_BITS.
- `nearly_full`  out  1: occupancy is at least 2**MAX_DEPTH_BITS - 1.
- `prog_full`  out  1: occupancy is at least PROG_FULL_THRESHOLD.
- `empty`  out  1: occupancy equals 0.

## Operation
- Storage is a register/RAM array of 2**MAX_DEPTH_BITS words.
  - Write pointer and read pointer are each MAX_DEPTH_BITS wide and wrap modulo depth.
  - Occupancy counter is MAX_DEPTH_BITS+1 wide, range 0..2**MAX_DEPTH_BITS.
- Write accepted iff `wr_en` & ~`full`.
  - Stores `din` at the write pointer, then increments the write pointer.
  - When `full`, a write is dropped even if `rd_en` is asserted in the same cycle. Flags are evaluated on pre-edge occupancy.
- Read accepted iff `rd_en` & ~`empty`.
  - Increments the read pointer.
  - A read while empty is ignored, with no pointer or count change.
- Occupancy update per edge: +1 for an accepted write only, -1 for an accepted read only, unchanged if both or neither.
- `dout` is the array entry at the read pointer, presented combinationally from storage (fall-through). No read latency: the head word is visible before `rd_en`.
- When `empty`=1, `dout` is don't-care. The implementation shall not drive X from uninitialised storage after reset; storage is zeroed on reset.
- All flags are decoded from the occupancy counter as registered state, with no combinational path from `wr_en`/`rd_en` to the flags.
- No error outputs. Overflow and underflow attempts are silently discarded.

## Timing
- Reset (sync, `reset`=1 at an edge) clears pointers, count and storage.
  - Outputs after that edge: `empty`=1, `full`=0, `nearly_full`=0, `dout`=0.
  - `prog_full`=0 unless PROG_FULL_THRESHOLD=0.
- Reset mid-operation discards all contents at that edge and overrides any simultaneous `wr_en`/`rd_en`.
- Write to read latency is 1 cycle: a word written at edge N gives `empty`=0 and `dout`=word immediately after edge N.
- Pop latency: with `rd_en`=1 at edge N, the next entry (or `empty`=1) appears after edge N.
- Simultaneous write and read when occupancy is 1: the old head is popped and the new word becomes head after the edge. `empty` stays 0.
- Simultaneous write and read when empty: only the write takes effect. `empty` deasserts after the edge.
- `nearly_full` asserts one entry before `full`, giving upstream one cycle of slack for registered `tready`.
- Pointer wrap from 2**MAX_DEPTH_BITS-1 to 0 is seamless. Order is preserved across wrap.

## Test plan
- **Reset state:** WIDTH=8, MAX_DEPTH_BITS=3; hold `reset` for 2 cycles. Require `empty`=1, `full`=0, `nearly_full`=0, `prog_full`=0.
- **Fall-through:** write 0xA5 for one cycle. Next cycle require `empty`=0 and `dout`=0xA5 with `rd_en`=0. Pulse `rd_en`; require `empty`=1 after.
- **Fill / overflow:** write 0x01..0x09 on consecutive cycles, no reads.
  - After the 7th write: `nearly_full`=1, `prog_full`=1, `full`=0.
  - After the 8th write: `full`=1.
  - The 9th write is dropped.
  - Drain 8 entries and require 0x01..0x08 in order, then `empty`=1.
- **Underflow:** while empty, assert `rd_en` for 3 cycles, then write 0x33. Require `dout`=0x33 with occupancy 1; no phantom entries.
- **Wrap with concurrent read/write:** stream 20 words 0x10..0x23 with `wr_en` and `rd_en` both active once non-empty. Require output order 0x10..0x23, occupancy never above 1, no drops.
- **Reset mid-stream:** write 5 words, assert `reset` together with `wr_en`=1 for one cycle. Require `empty`=1 and count 0 after; the next write of 0x77 appears on `dout`.
